// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state enum, default divide latency and dependency-match helper for pipeline_hazard_ctrl
package hazard_pkg;
  typedef enum logic {RUN, DIV_BUSY} div_state_e;
  localparam int DIV_LAT_DEF = 8;
  function automatic logic dep_match(input logic wr, input logic [4:0] dst, input logic [4:0] rs, input logic use_rs, input logic [4:0] rt, input logic use_rt);
    return wr && (dst != 5'd0) && ((dst == rs && use_rs) || (dst == rt && use_rt));
  endfunction
endpackage

// File: rtl/div_busy_timer.sv
// div_busy_timer: tracks EX occupancy of a multi-cycle divide, giving div_busy, div_done and the div-stall flag
module div_busy_timer
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic is_div,
  output logic div_busy,
  output logic div_done,
  output logic div_stall
);
  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LAT - 2);
  div_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = (state == RUN) ? (is_div ? DIV_BUSY : RUN) : ((cnt == '0) ? RUN : DIV_BUSY);
    cnt_nxt   = (state == RUN) ? (is_div ? CNT_INIT : cnt) : ((cnt == '0) ? cnt : cnt - 1'b1);
  end
  always_comb begin
    div_busy  = !rst && (state == DIV_BUSY);
    div_done  = !rst && (state == DIV_BUSY) && (cnt == '0);
    div_stall = !rst && ((state == RUN) ? is_div : (cnt != '0));
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC/IF-ID/ID-EX stall and flush sequencer for load-use, ID-branch and divide hazards (HAZARD_PERF_EN adds stall_cnt/flush_cnt)
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic       ID_Branch,
  input  logic       BranchTaken,
  input  logic       ID_EX_RegWr,
  input  logic       ID_EX_MemRd,
  input  logic       ID_EX_IsDiv,
  input  logic [4:0] ID_EX_RegWrAddr,
  input  logic       EX_MEM_RegWr,
  input  logic       EX_MEM_MemRd,
  input  logic [4:0] EX_MEM_RegWrAddr,
  output logic       PC_Wr,
  output logic       IF_ID_Wr,
  output logic       ID_EX_Wr,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       EX_MEM_Flush,
  output logic       div_busy,
  output logic       div_done
`ifdef HAZARD_PERF_EN
  ,output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  logic div_stall, ex_match, mem_match, hz;
  div_busy_timer #(.DIV_LAT(DIV_LAT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .is_div    (ID_EX_IsDiv),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_stall (div_stall)
  );
  always_comb begin
    ex_match     = dep_match(ID_EX_RegWr, ID_EX_RegWrAddr, ID_Rs, ID_UseRs, ID_Rt, ID_UseRt);
    mem_match    = dep_match(EX_MEM_RegWr, EX_MEM_RegWrAddr, ID_Rs, ID_UseRs, ID_Rt, ID_UseRt);
    hz           = !rst && !div_stall && ((ID_EX_MemRd && ex_match) || (ID_Branch && (ex_match || (EX_MEM_MemRd && mem_match))));
    PC_Wr        = !(div_stall || hz);
    IF_ID_Wr     = !(div_stall || hz);
    ID_EX_Wr     = !div_stall;
    IF_ID_Flush  = !rst && !div_stall && !hz && BranchTaken;
    ID_EX_Flush  = hz;
    EX_MEM_Flush = div_stall;
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, !PC_Wr};
      flush_cnt <= flush_cnt + {31'd0, IF_ID_Flush};
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with a queue scoreboard checking stall/flush outputs every cycle
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_Rs, ID_Rt, ID_EX_RegWrAddr, EX_MEM_RegWrAddr;
  logic ID_UseRs, ID_UseRt, ID_Branch, BranchTaken;
  logic ID_EX_RegWr, ID_EX_MemRd, ID_EX_IsDiv, EX_MEM_RegWr, EX_MEM_MemRd;
  logic PC_Wr, IF_ID_Wr, ID_EX_Wr, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, div_busy, div_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
`endif
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.DIV_LAT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_Rs            (ID_Rs),
    .ID_Rt            (ID_Rt),
    .ID_UseRs         (ID_UseRs),
    .ID_UseRt         (ID_UseRt),
    .ID_Branch        (ID_Branch),
    .BranchTaken      (BranchTaken),
    .ID_EX_RegWr      (ID_EX_RegWr),
    .ID_EX_MemRd      (ID_EX_MemRd),
    .ID_EX_IsDiv      (ID_EX_IsDiv),
    .ID_EX_RegWrAddr  (ID_EX_RegWrAddr),
    .EX_MEM_RegWr     (EX_MEM_RegWr),
    .EX_MEM_MemRd     (EX_MEM_MemRd),
    .EX_MEM_RegWrAddr (EX_MEM_RegWrAddr),
    .PC_Wr            (PC_Wr),
    .IF_ID_Wr         (IF_ID_Wr),
    .ID_EX_Wr         (ID_EX_Wr),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Flush      (ID_EX_Flush),
    .EX_MEM_Flush     (EX_MEM_Flush),
    .div_busy         (div_busy),
    .div_done         (div_done)
`ifdef HAZARD_PERF_EN
    ,.stall_cnt       (stall_cnt),
    .flush_cnt        (flush_cnt)
`endif
  );
  // {PC_Wr, IF_ID_Wr, ID_EX_Wr, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, div_busy, div_done}
  localparam logic [7:0] RUN_V  = 8'b111_000_00;
  localparam logic [7:0] HZ_V   = 8'b001_010_00;
  localparam logic [7:0] BRF_V  = 8'b111_100_00;
  localparam logic [7:0] DIV0_V = 8'b000_001_00;
  localparam logic [7:0] DIVB_V = 8'b000_001_10;
  localparam logic [7:0] DONE_V = 8'b111_000_11;
  localparam logic [7:0] DHZ_V  = 8'b001_010_11;
  typedef struct {
    logic [7:0] exp;
    logic       r;
    string      name;
  } item_t;
  item_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  task automatic apply(input string name, input logic r,
                       input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic bt,
                       input logic exwr, input logic exrd, input logic exdiv, input logic [4:0] exdst,
                       input logic memwr, input logic memrd, input logic [4:0] memdst,
                       input logic [7:0] exp);
    @(posedge clk);
    #1;
    rst = r;
    ID_Rs = rs; ID_UseRs = urs; ID_Rt = rt; ID_UseRt = urt;
    ID_Branch = br; BranchTaken = bt;
    ID_EX_RegWr = exwr; ID_EX_MemRd = exrd; ID_EX_IsDiv = exdiv; ID_EX_RegWrAddr = exdst;
    EX_MEM_RegWr = memwr; EX_MEM_MemRd = memrd; EX_MEM_RegWrAddr = memdst;
    sb.push_back('{exp: exp, r: r, name: name});
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      logic [7:0] act;
      it = sb.pop_front();
      act = {PC_Wr, IF_ID_Wr, ID_EX_Wr, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, div_busy, div_done};
      vectors++;
      if (act !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", it.name, act, it.exp);
      end
`ifdef HAZARD_PERF_EN
      vectors++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        miscompares++;
        $display("FAIL %s perf: got %0d/%0d want %0d/%0d", it.name, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      m_stall = it.r ? 32'd0 : m_stall + {31'd0, !it.exp[7]};
      m_flush = it.r ? 32'd0 : m_flush + {31'd0, it.exp[4]};
`endif
    end
  end
  initial begin
    rst = 1'b1;
    {ID_Rs, ID_Rt, ID_EX_RegWrAddr, EX_MEM_RegWrAddr} = '0;
    {ID_UseRs, ID_UseRt, ID_Branch, BranchTaken, ID_EX_RegWr, ID_EX_MemRd, ID_EX_IsDiv, EX_MEM_RegWr, EX_MEM_MemRd} = '0;
    // reset masks every hazard and the divide request
    apply("reset0", 1, 5'd5, 1, 5'd0, 0, 1, 1, 1, 1, 1, 5'd5, 0, 0, 5'd0, RUN_V);
    apply("reset1", 1, 5'd5, 1, 5'd0, 0, 1, 1, 1, 1, 1, 5'd5, 0, 0, 5'd0, RUN_V);
    apply("idle", 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, RUN_V);
    // load-use on r5: one stall, then the load sits in MEM
    apply("lu_rs", 0, 5'd5, 1, 5'd0, 0, 0, 0, 1, 1, 0, 5'd5, 0, 0, 5'd0, HZ_V);
    apply("lu_after", 0, 5'd5, 1, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 1, 1, 5'd5, RUN_V);
    apply("lu_r0", 0, 5'd0, 1, 5'd0, 1, 0, 0, 1, 1, 0, 5'd0, 0, 0, 5'd0, RUN_V);
    apply("lu_rt_unused", 0, 5'd1, 1, 5'd6, 0, 0, 0, 1, 1, 0, 5'd6, 0, 0, 5'd0, RUN_V);
    apply("lu_rt", 0, 5'd1, 1, 5'd6, 1, 0, 0, 1, 1, 0, 5'd6, 0, 0, 5'd0, HZ_V);
    apply("lu_nowr", 0, 5'd6, 1, 5'd0, 0, 0, 0, 0, 1, 0, 5'd6, 0, 0, 5'd0, RUN_V);
    // ALU producer in EX: forwarded for ALU ops, stalls an ID branch
    apply("alu_fwd", 0, 5'd3, 1, 5'd0, 0, 0, 0, 1, 0, 0, 5'd3, 0, 0, 5'd0, RUN_V);
    apply("br_alu_ex", 0, 5'd3, 1, 5'd0, 0, 1, 0, 1, 0, 0, 5'd3, 0, 0, 5'd0, HZ_V);
    apply("br_alu_mem", 0, 5'd3, 1, 5'd0, 0, 1, 0, 0, 0, 0, 5'd0, 1, 0, 5'd3, RUN_V);
    // branch on r7 loaded: two stalls with taken ignored, then one-cycle flush
    apply("br_ld_ex", 0, 5'd2, 0, 5'd7, 1, 1, 1, 1, 1, 0, 5'd7, 0, 0, 5'd0, HZ_V);
    apply("br_ld_mem", 0, 5'd2, 0, 5'd7, 1, 1, 1, 0, 0, 0, 5'd0, 1, 1, 5'd7, HZ_V);
    apply("br_taken", 0, 5'd2, 0, 5'd7, 1, 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, BRF_V);
    apply("br_next", 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, RUN_V);
    // divide: 7 stall cycles (taken ignored) then div_done
    apply("div_T", 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 1, 5'd9, 0, 0, 5'd0, DIV0_V);
    for (int i = 1; i <= 6; i++)
      apply("div_busy", 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, 0, 1, 5'd9, 0, 0, 5'd0, DIVB_V);
    apply("div_done", 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 1, 5'd9, 0, 0, 5'd0, DONE_V);
    apply("div_after", 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 1, 0, 5'd9, RUN_V);
    // second divide with a dependent branch: BR_HAZ raised at div_done
    apply("div2_T", 0, 5'd9, 1, 5'd0, 0, 1, 0, 1, 0, 1, 5'd9, 0, 0, 5'd0, DIV0_V);
    for (int i = 1; i <= 6; i++)
      apply("div2_busy", 0, 5'd9, 1, 5'd0, 0, 1, 0, 1, 0, 1, 5'd9, 0, 0, 5'd0, DIVB_V);
    apply("div2_done_brhaz", 0, 5'd9, 1, 5'd0, 0, 1, 1, 1, 0, 1, 5'd9, 0, 0, 5'd0, DHZ_V);
    apply("div2_br_taken", 0, 5'd9, 1, 5'd0, 0, 1, 1, 0, 0, 0, 5'd0, 1, 0, 5'd9, BRF_V);
    // reset while cnt == 3 aborts the divide
    apply("div3_T", 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 1, 5'd4, 0, 0, 5'd0, DIV0_V);
    for (int i = 1; i <= 3; i++)
      apply("div3_busy", 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 1, 5'd4, 0, 0, 5'd0, DIVB_V);
    apply("div3_rst", 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 1, 5'd4, 0, 0, 5'd0, RUN_V);
    apply("div3_post", 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, BRF_V);
    apply("final", 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, RUN_V);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard sequencer for the 5-stage LoongArch pipeline. Decides every cycle whether PC, IF/ID and ID/EX advance, stall or flush. It covers three cases: load-use hazards, ID-stage branch operand hazards that forwarding cannot resolve, and multi-cycle divide occupancy of EX. It also kills the wrong-path fetch after a taken branch. It sits beside the branch forwarding unit in ID and drives the write/flush enables of PC and the pipeline registers.

## Interface
Parameters:
- DIV_LAT, 8, total EX-stage cycles occupied by a divide; legal range 2..64.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ID_Rs, ID_Rt  in  5 each  source registers of instruction in ID
- ID_UseRs, ID_UseRt  in  1 each  instruction in ID actually reads Rs / Rt
- ID_Branch  in  1  instruction in ID is a compare-branch resolved in ID
- BranchTaken  in  1  ID branch resolved taken this cycle
- ID_EX_RegWr, ID_EX_MemRd, ID_EX_IsDiv  in  1 each  EX-stage instruction writes reg / is load / is divide
- ID_EX_RegWrAddr  in  5  EX-stage destination
- EX_MEM_RegWr, EX_MEM_MemRd  in  1 each  MEM-stage instruction writes reg / is load
- EX_MEM_RegWrAddr  in  5  MEM-stage destination
- PC_Wr, IF_ID_Wr, ID_EX_Wr  out  1 each  register write enables
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  out  1 each  insert bubble into named register
- div_busy  out  1  divide sequence in progress (registered state)
- div_done  out  1  final EX cycle of a divide
- stall_cnt, flush_cnt  out  32 each  only with HAZARD_PERF_EN

## Operation
- Dependency match: dest != 0, dest's RegWr = 1, and (dest == ID_Rs & ID_UseRs) | (dest == ID_Rt & ID_UseRt).
- LOAD_USE: ID_EX_MemRd with EX match.
- BR_HAZ: ID_Branch and either EX match (ALU result not yet in EX/MEM) or EX_MEM_MemRd with MEM match.
- FSM states: RUN, DIV_BUSY. Counter cnt width clog2(DIV_LAT).
- RUN, ID_EX_IsDiv = 1: DIV stall this cycle; cnt <= DIV_LAT-2; next DIV_BUSY.
- DIV_BUSY, cnt != 0: DIV stall; cnt--.
- DIV_BUSY, cnt == 0: div_done = 1, no DIV stall, next RUN.
- Priority: DIV stall > LOAD_USE / BR_HAZ > taken-branch flush.
- DIV stall: PC_Wr = IF_ID_Wr = ID_EX_Wr = 0, EX_MEM_Flush = 1, other flushes 0.
- LOAD_USE / BR_HAZ stall: PC_Wr = IF_ID_Wr = 0, ID_EX_Wr = 1, ID_EX_Flush = 1.
- No stall and BranchTaken: all enables 1, IF_ID_Flush = 1.
- BranchTaken is ignored during any stall, because operands are not yet valid.
- Otherwise all enables 1 and all flushes 0.
- div_busy = (state == DIV_BUSY).

## Timing
- Stall/flush outputs are combinational from inputs plus registered state; zero added latency.
- Divide issued into ID/EX at cycle T: stall cycles T..T+DIV_LAT-2; div_done at T+DIV_LAT-1; ID/EX reloads at the edge ending T+DIV_LAT-1.
- Load-use: exactly 1 stall cycle.
- BR_HAZ on an ALU producer in EX: 1 cycle. BR_HAZ on a load: 2 cycles (EX, then MEM).
- At div_done, a dependent branch in ID raises BR_HAZ in the same cycle.
- rst high: next state RUN, cnt 0, counters 0. Outputs during reset cycles: div_busy 0, div_done 0, enables 1, flushes 0.
- rst mid-divide: aborts immediately; RUN next cycle.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with PC_Wr = 0.
  - flush_cnt increments on every cycle with IF_ID_Flush = 1.
  - Both are 32-bit, wrap 0xFFFFFFFF -> 0, and are cleared by rst.
- HAZARD_PERF_EN undefined: both ports and their registers are absent.

## Structure
- hazard_pkg holds the state enum (RUN, DIV_BUSY) and the DIV_LAT default constant.
- One sub-module, div_busy_timer: owns the FSM and cnt, takes IsDiv, and returns div_busy, div_done and the div-stall flag.
- Dependency compare and priority mux live in the top level.

## Test plan
- Load r5 in EX, ID add reads r5 -> one cycle PC_Wr = 0, ID_EX_Flush = 1; next cycle all enables 1.
- Load to r0 in EX, ID reads r0 -> no stall.
- ID_Branch reads r7, r7 load in EX -> 2 stall cycles; then BranchTaken = 1 -> IF_ID_Flush = 1 for exactly one cycle.
- DIV_LAT = 8, divide enters EX at T -> EX_MEM_Flush = 1 for T..T+6, div_done at T+7, stall_cnt += 7.
- BranchTaken asserted during DIV_BUSY -> IF_ID_Flush stays 0.
- rst asserted at DIV_BUSY cnt = 3 -> div_busy 0 the following cycle, enables all 1, counters 0.
